// File: rtl/perf_event_counter_bank.sv
// perf_event_counter_bank
// A bank of NUM_EVENTS performance counters. The whole bank is captured into a
// one-deep output buffer on snapshot_req and handed off with valid/ready. A
// small register port controls enable, wrap/saturate mode and the event mask,
// and exposes a count of snapshots that were dropped because the buffer was busy.
// Optional build macro: PERF_OVERFLOW_FLAGS_EN adds one sticky overflow flag
// per counter, carried in the MSBs of out_data.
module perf_event_counter_bank #(
   parameter int NUM_EVENTS      = 39,
   parameter int COUNTER_WIDTH   = 7,
   parameter int CTRL_ADDR_WIDTH = 8,
   parameter int CTRL_DATA_WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_EVENTS-1:0]      event_in,
   input  logic                       snapshot_req,
`ifdef PERF_OVERFLOW_FLAGS_EN
   output logic [NUM_EVENTS*COUNTER_WIDTH+NUM_EVENTS-1:0] out_data,
`else
   output logic [NUM_EVENTS*COUNTER_WIDTH-1:0]            out_data,
`endif
   output logic                       out_valid,
   input  logic                       out_ready,
   input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
   input  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
   input  logic                       ctrl_write_enable,
   output logic [CTRL_DATA_WIDTH-1:0] ctrl_rdata
);

   localparam int W = COUNTER_WIDTH;
`ifdef PERF_OVERFLOW_FLAGS_EN
   localparam int OUT_W = NUM_EVENTS * W + NUM_EVENTS;
`else
   localparam int OUT_W = NUM_EVENTS * W;
`endif

   typedef enum logic {
      BUF_EMPTY,
      BUF_FULL
   } buf_state_t;

   buf_state_t state_q, state_d;

   logic [NUM_EVENTS-1:0][W-1:0] cnt_q, cnt_d;
   logic                         enable_q;
   logic                         sat_mode_q;
   logic [NUM_EVENTS-1:0]        event_mask_q;
   logic [31:0]                  dropped_q;
   logic [OUT_W-1:0]             out_data_q;
   logic [OUT_W-1:0]             capture_data;
`ifdef PERF_OVERFLOW_FLAGS_EN
   logic [NUM_EVENTS-1:0]        ovf_q, ovf_d;
`endif

   logic                  capture;
   logic                  drop;
   logic [NUM_EVENTS-1:0] counted;
   logic                  wr_enable;
   logic                  wr_sat_mode;
   logic                  wr_mask;
   logic                  wr_dropped;
   logic                  wr_clear;
   logic                  unused_wdata;

   assign wr_enable   = ctrl_write_enable && (ctrl_addr == CTRL_ADDR_WIDTH'(0));
   assign wr_sat_mode = ctrl_write_enable && (ctrl_addr == CTRL_ADDR_WIDTH'(1));
   assign wr_mask     = ctrl_write_enable && (ctrl_addr == CTRL_ADDR_WIDTH'(2));
   assign wr_dropped  = ctrl_write_enable && (ctrl_addr == CTRL_ADDR_WIDTH'(3));
   assign wr_clear    = ctrl_write_enable && (ctrl_addr == CTRL_ADDR_WIDTH'(4));

   // Only the low bits of most registers are meaningful; the rest of the write
   // word is deliberately ignored.
   assign unused_wdata = ^ctrl_wdata;

   // An event only counts when the bank is enabled and its mask bit is set.
   assign counted = event_in & event_mask_q & {NUM_EVENTS{enable_q}};

   assign out_data  = out_data_q;
   assign out_valid = (state_q == BUF_FULL);

`ifdef PERF_OVERFLOW_FLAGS_EN
   assign capture_data = {ovf_q, cnt_q};
`else
   assign capture_data = cnt_q;
`endif

   // Register read mux; purely combinational so software sees the current value.
   always_comb begin
      ctrl_rdata = '0;
      case (ctrl_addr)
         CTRL_ADDR_WIDTH'(0): ctrl_rdata[0] = enable_q;
         CTRL_ADDR_WIDTH'(1): ctrl_rdata[0] = sat_mode_q;
         CTRL_ADDR_WIDTH'(2): ctrl_rdata[NUM_EVENTS-1:0] = event_mask_q;
         CTRL_ADDR_WIDTH'(3): ctrl_rdata[31:0] = dropped_q;
         default:             ctrl_rdata = '0;
      endcase
   end

   // Output buffer control: capture when there is room (or room is being made
   // this cycle), otherwise count the request as dropped.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      drop    = 1'b0;
      case (state_q)
         BUF_EMPTY: begin
            if (snapshot_req) begin
               capture = 1'b1;
               state_d = BUF_FULL;
            end
         end
         BUF_FULL: begin
            if (out_ready) begin
               if (snapshot_req) begin
                  capture = 1'b1;
                  state_d = BUF_FULL;
               end else begin
                  state_d = BUF_EMPTY;
               end
            end else if (snapshot_req) begin
               drop = 1'b1;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase
   end

   // Next counter values. CLEAR beats a restart, which beats normal counting; a
   // restart seeds the counter with this cycle's event so nothing is lost.
   always_comb begin
      cnt_d = cnt_q;
`ifdef PERF_OVERFLOW_FLAGS_EN
      ovf_d = ovf_q;
`endif
      for (int i = 0; i < NUM_EVENTS; i++) begin
         if (wr_clear) begin
            cnt_d[i] = '0;
`ifdef PERF_OVERFLOW_FLAGS_EN
            ovf_d[i] = 1'b0;
`endif
         end else if (capture) begin
            cnt_d[i] = W'(counted[i]);
`ifdef PERF_OVERFLOW_FLAGS_EN
            ovf_d[i] = 1'b0;
`endif
         end else if (counted[i]) begin
            if (cnt_q[i] == {W{1'b1}}) begin
`ifdef PERF_OVERFLOW_FLAGS_EN
               ovf_d[i] = 1'b1;
`endif
               if (!sat_mode_q) begin
                  cnt_d[i] = '0;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + W'(1);
            end
         end
      end
   end

   // Buffer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BUF_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Counter (and overflow flag) registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
`ifdef PERF_OVERFLOW_FLAGS_EN
         ovf_q <= '0;
`endif
      end else begin
         cnt_q <= cnt_d;
`ifdef PERF_OVERFLOW_FLAGS_EN
         ovf_q <= ovf_d;
`endif
      end
   end

   // Captured data holds steady until the next accepted snapshot.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q <= '0;
      end else if (capture) begin
         out_data_q <= capture_data;
      end
   end

   // Control registers written from the register port.
   always_ff @(posedge clk) begin
      if (rst) begin
         enable_q     <= 1'b0;
         sat_mode_q   <= 1'b0;
         event_mask_q <= '1;
      end else begin
         if (wr_enable) begin
            enable_q <= ctrl_wdata[0];
         end
         if (wr_sat_mode) begin
            sat_mode_q <= ctrl_wdata[0];
         end
         if (wr_mask) begin
            event_mask_q <= ctrl_wdata[NUM_EVENTS-1:0];
         end
      end
   end

   // Dropped-snapshot counter: any write clears it, otherwise it saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         dropped_q <= '0;
      end else if (wr_dropped) begin
         dropped_q <= '0;
      end else if (drop && (dropped_q != 32'hFFFF_FFFF)) begin
         dropped_q <= dropped_q + 32'd1;
      end
   end

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Testbench for perf_event_counter_bank: a table of register-port vectors
// followed by hand-written multi-cycle sequences for capture, drop, restart,
// wrap/saturate, CLEAR and reset behaviour.
module tb_perf_event_counter_bank;

   localparam int NE = 39;
   localparam int W  = 7;
`ifdef PERF_OVERFLOW_FLAGS_EN
   localparam int OUT_W = NE * W + NE;
`else
   localparam int OUT_W = NE * W;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NE-1:0]     event_in;
   logic              snapshot_req;
   logic [OUT_W-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        ctrl_addr;
   logic [63:0]       ctrl_wdata;
   logic              ctrl_write_enable;
   logic [63:0]       ctrl_rdata;

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic [7:0]  addr;
      logic [63:0] wdata;
      logic        we;
      logic        chk;
      logic [63:0] exp;
   } ctrl_vec_t;

   ctrl_vec_t vecs[18];

   perf_event_counter_bank #(
      .NUM_EVENTS(NE),
      .COUNTER_WIDTH(W),
      .CTRL_ADDR_WIDTH(8),
      .CTRL_DATA_WIDTH(64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .event_in(event_in),
      .snapshot_req(snapshot_req),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .ctrl_addr(ctrl_addr),
      .ctrl_wdata(ctrl_wdata),
      .ctrl_write_enable(ctrl_write_enable),
      .ctrl_rdata(ctrl_rdata)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   function automatic logic [63:0] cntOf(int i);
      return 64'(out_data[i*W +: W]);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      event_in = '0;
      snapshot_req = 1'b0;
      out_ready = 1'b0;
      ctrl_addr = '0;
      ctrl_wdata = '0;
      ctrl_write_enable = 1'b0;
      step(2);
      rst = 1'b0;
   endtask

   task automatic ctrlWrite(input logic [7:0] a, input logic [63:0] d);
      ctrl_addr = a;
      ctrl_wdata = d;
      ctrl_write_enable = 1'b1;
      step(1);
      ctrl_write_enable = 1'b0;
      ctrl_wdata = '0;
   endtask

   task automatic checkReg(input string name, input logic [7:0] a, input logic [63:0] exp);
      ctrl_addr = a;
      #1;
      checkOutput(name, ctrl_rdata, exp);
   endtask

   task automatic snapshot();
      snapshot_req = 1'b1;
      step(1);
      snapshot_req = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
   endtask

   task automatic applyStimulus(input ctrl_vec_t v, input int idx);
      ctrl_addr = v.addr;
      ctrl_wdata = v.wdata;
      ctrl_write_enable = v.we;
      #1;
      if (v.chk) begin
         checkOutput($sformatf("ctrl_vec%0d", idx), ctrl_rdata, v.exp);
      end
      step(1);
      ctrl_write_enable = 1'b0;
   endtask

   initial begin
      // Register-port table: {addr, wdata, we, check, expected rdata}.
      // A write vector's check sees the value before the write lands.
      vecs[0]  = '{8'd0, 64'd0,                   1'b0, 1'b1, 64'd0};
      vecs[1]  = '{8'd1, 64'd0,                   1'b0, 1'b1, 64'd0};
      vecs[2]  = '{8'd2, 64'd0,                   1'b0, 1'b1, 64'h0000_007F_FFFF_FFFF};
      vecs[3]  = '{8'd3, 64'd0,                   1'b0, 1'b1, 64'd0};
      vecs[4]  = '{8'd4, 64'd0,                   1'b0, 1'b1, 64'd0};
      vecs[5]  = '{8'd9, 64'd0,                   1'b0, 1'b1, 64'd0};
      vecs[6]  = '{8'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'd0};
      vecs[7]  = '{8'd2, 64'd0,                   1'b0, 1'b1, 64'h0000_007F_FFFF_FFFF};
      vecs[8]  = '{8'd2, 64'h5,                   1'b1, 1'b0, 64'd0};
      vecs[9]  = '{8'd2, 64'd0,                   1'b0, 1'b1, 64'h5};
      vecs[10] = '{8'd1, 64'h3,                   1'b1, 1'b0, 64'd0};
      vecs[11] = '{8'd1, 64'd0,                   1'b0, 1'b1, 64'd1};
      vecs[12] = '{8'd0, 64'h1,                   1'b1, 1'b1, 64'd0};
      vecs[13] = '{8'd0, 64'd0,                   1'b0, 1'b1, 64'd1};
      vecs[14] = '{8'd6, 64'hFFFF,                1'b1, 1'b0, 64'd0};
      vecs[15] = '{8'd6, 64'd0,                   1'b0, 1'b1, 64'd0};
      vecs[16] = '{8'd4, 64'h1,                   1'b1, 1'b0, 64'd0};
      vecs[17] = '{8'd4, 64'd0,                   1'b0, 1'b1, 64'd0};

      doReset();
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_data_zero", 64'(|out_data), 64'd0);
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Five events on bit 0, one snapshot, one beat out.
      doReset();
      ctrlWrite(8'd0, 64'd1);
      event_in = NE'(1);
      step(5);
      event_in = '0;
      snapshot();
      checkOutput("basic_valid", 64'(out_valid), 64'd1);
      checkOutput("basic_cnt0", cntOf(0), 64'd5);
      checkOutput("basic_cnt1", cntOf(1), 64'd0);
      checkOutput("basic_cnt38", cntOf(38), 64'd0);
      drain();
      checkOutput("basic_drained", 64'(out_valid), 64'd0);
      // With counting disabled events are ignored but snapshots still work.
      ctrlWrite(8'd0, 64'd0);
      event_in = '1;
      step(3);
      snapshot();
      event_in = '0;
      checkOutput("disabled_valid", 64'(out_valid), 64'd1);
      checkOutput("disabled_cnt0", cntOf(0), 64'd0);
      checkOutput("disabled_cnt20", cntOf(20), 64'd0);
      drain();

      // 130 events on bit 3: wrap gives 2, saturate gives 127.
      doReset();
      ctrlWrite(8'd0, 64'd1);
      event_in = NE'(1) << 3;
      step(130);
      event_in = '0;
      snapshot();
      checkOutput("wrap_cnt3", cntOf(3), 64'd2);
`ifdef PERF_OVERFLOW_FLAGS_EN
      checkOutput("wrap_flag3", 64'(out_data[NE*W+3]), 64'd1);
      checkOutput("wrap_flag0", 64'(out_data[NE*W+0]), 64'd0);
`endif
      drain();
      ctrlWrite(8'd1, 64'd1);
      event_in = NE'(1) << 3;
      step(130);
      event_in = '0;
      snapshot();
      checkOutput("sat_cnt3", cntOf(3), 64'd127);
`ifdef PERF_OVERFLOW_FLAGS_EN
      checkOutput("sat_flag3", 64'(out_data[NE*W+3]), 64'd1);
`endif
      drain();

      // Dropped snapshot while the consumer stalls.
      doReset();
      ctrlWrite(8'd0, 64'd1);
      event_in = NE'(1) << 2;
      step(3);
      snapshot();
      checkOutput("drop_first_valid", 64'(out_valid), 64'd1);
      checkOutput("drop_first_cnt2", cntOf(2), 64'd3);
      step(2);
      snapshot();
      event_in = '0;
      checkOutput("drop_stable_cnt2", cntOf(2), 64'd3);
      checkOutput("drop_still_valid", 64'(out_valid), 64'd1);
      checkReg("drop_count", 8'd3, 64'd1);
      drain();
      checkOutput("drop_drained", 64'(out_valid), 64'd0);
      snapshot();
      checkOutput("drop_second_cnt2", cntOf(2), 64'd4);
      drain();
      ctrlWrite(8'd3, 64'd0);
      checkReg("drop_count_cleared", 8'd3, 64'd0);

      // Transfer and new capture in the same cycle; counter 1 restarts at 1.
      doReset();
      ctrlWrite(8'd0, 64'd1);
      event_in = NE'(1) << 1;
      step(2);
      event_in = '0;
      snapshot();
      checkOutput("b2b_first_cnt1", cntOf(1), 64'd2);
      event_in = NE'(1) << 1;
      step(3);
      out_ready = 1'b1;
      snapshot();
      event_in = '0;
      checkOutput("b2b_valid", 64'(out_valid), 64'd1);
      checkOutput("b2b_cnt1", cntOf(1), 64'd3);
      step(1);
      out_ready = 1'b0;
      checkOutput("b2b_drained", 64'(out_valid), 64'd0);
      snapshot();
      checkOutput("b2b_restart_cnt1", cntOf(1), 64'd1);
      drain();

      // Event mask plus CLEAR coinciding with a snapshot.
      doReset();
      ctrlWrite(8'd0, 64'd1);
      ctrlWrite(8'd2, 64'd1);
      event_in = '1;
      step(10);
      ctrl_addr = 8'd4;
      ctrl_wdata = 64'd1;
      ctrl_write_enable = 1'b1;
      snapshot();
      ctrl_write_enable = 1'b0;
      event_in = '0;
      checkOutput("mask_valid", 64'(out_valid), 64'd1);
      checkOutput("mask_cnt0", cntOf(0), 64'd10);
      checkOutput("mask_cnt1", cntOf(1), 64'd0);
      checkOutput("mask_cnt38", cntOf(38), 64'd0);
      ctrlWrite(8'd4, 64'd1);
      checkOutput("clear_keeps_valid", 64'(out_valid), 64'd1);
      checkOutput("clear_keeps_data", cntOf(0), 64'd10);
      drain();
      snapshot();
      checkOutput("clear_cnt0", cntOf(0), 64'd0);
      drain();

      // Reset while a beat is pending overrides every same-cycle input.
      doReset();
      ctrlWrite(8'd0, 64'd1);
      event_in = NE'(1);
      step(4);
      snapshot();
      snapshot();
      event_in = '0;
      checkReg("rstmid_drop_before", 8'd3, 64'd1);
      rst = 1'b1;
      out_ready = 1'b1;
      snapshot_req = 1'b1;
      event_in = '1;
      step(1);
      rst = 1'b0;
      out_ready = 1'b0;
      snapshot_req = 1'b0;
      event_in = '0;
      checkOutput("rstmid_valid", 64'(out_valid), 64'd0);
      checkOutput("rstmid_data_zero", 64'(|out_data), 64'd0);
      checkReg("rstmid_dropped", 8'd3, 64'd0);
      checkReg("rstmid_enable", 8'd0, 64'd0);
      checkReg("rstmid_mask", 8'd2, 64'h0000_007F_FFFF_FFFF);
      snapshot();
      checkOutput("rstmid_cnt0", cntOf(0), 64'd0);
      drain();

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/perf_event_counter_bank.md
PERF_EVENT_COUNTER_BANK -- requirements
Module: perf_event_counter_bank

Interface
REQ-001 Parameter NUM_EVENTS, default 39, number of event inputs/counters; legal range 1..64.
REQ-002 Parameter COUNTER_WIDTH, default 7, width W of each counter.
REQ-003 Parameter CTRL_ADDR_WIDTH, default 8; CTRL_DATA_WIDTH, default 64.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 event_in  input  NUM_EVENTS  per-cycle event pulses, bit i increments counter i.
REQ-007 snapshot_req  input  1  request to capture all counters, e.g. on trace item emission.
REQ-008 out_data  output  NUM_EVENTS*W (+NUM_EVENTS with PERF_OVERFLOW_FLAGS_EN)  captured counters, counter i at bits [i*W +: W]; overflow flags, if present, in the MSBs.
REQ-009 out_valid  output  1; out_ready  input  1  valid/ready handshake for out_data.
REQ-010 ctrl_addr  input  CTRL_ADDR_WIDTH; ctrl_wdata  input  CTRL_DATA_WIDTH; ctrl_write_enable  input  1; ctrl_rdata  output  CTRL_DATA_WIDTH  control port.

Function
REQ-011 Control map: 0 ENABLE (bit0), 1 SATURATE_MODE (bit0), 2 EVENT_MASK (bits NUM_EVENTS-1:0, 1 = counted), 3 DROPPED_COUNT (read; any write clears), 4 CLEAR (write clears all counters); others read 0, writes ignored.
REQ-012 ctrl_rdata combinational from ctrl_addr; writes take effect next cycle.
REQ-013 Counting: when ENABLE=1, counter i increments by 1 in each cycle where event_in[i] & EVENT_MASK[i]; ENABLE=0 holds counters.
REQ-014 Wrap mode (SATURATE_MODE=0): counter wraps 2^W-1 -> 0.
REQ-015 Saturate mode: counter holds at 2^W-1.
REQ-016 Output buffer states: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-017 EMPTY + snapshot_req: out_data <= current counters (pre-increment), out_valid=1 next cycle, FULL; counters restart in same cycle at that cycle's masked event (0 or 1).
REQ-018 FULL + out_ready: transfer; EMPTY next cycle unless REQ-019.
REQ-019 FULL + out_ready + snapshot_req same cycle: new capture per REQ-017, stays FULL.
REQ-020 FULL + !out_ready + snapshot_req: snapshot dropped, counters keep accumulating (not cleared), DROPPED_COUNT +1, saturating at 2^32-1.
REQ-021 out_data stable while out_valid=1 and out_ready=0.
REQ-022 CLEAR write and snapshot_req same cycle: capture pre-clear values; counters become 0 (event in that cycle ignored).
REQ-023 CLEAR does not affect out_data, out_valid or DROPPED_COUNT.
REQ-024 Snapshots accepted regardless of ENABLE.

Reset
REQ-025 rst: counters 0, out_data 0, out_valid 0, state EMPTY, ENABLE 0, SATURATE_MODE 0, EVENT_MASK all-ones, DROPPED_COUNT 0, overflow flags 0.
REQ-026 rst mid-transfer discards pending out_data with no handshake completion; rst overrides all same-cycle inputs.

Configuration
REQ-027 Macro PERF_OVERFLOW_FLAGS_EN defined: per-counter sticky overflow flag, set when counter at 2^W-1 receives a counted event (either mode), captured into out_data MSBs on snapshot, cleared with counter restart (REQ-017) and on CLEAR.
REQ-028 Macro undefined: no flags, out_data width exactly NUM_EVENTS*W.

Verification
REQ-029 Reset, ENABLE=1, event_in[0] high 5 cycles, snapshot_req, out_ready=1 -> one beat, counter0=5, others 0, then out_valid=0.
REQ-030 W=7, wrap mode, 130 events on bit 3, snapshot -> counter3=2; saturate mode repeat -> 127; with macro, flag3=1 in both.
REQ-031 out_ready=0, two snapshot_req -> out_data unchanged from first, DROPPED_COUNT=1, second snapshot after out_ready shows events accumulated since first.
REQ-032 FULL, out_ready and snapshot_req same cycle with event_in[1]=1 -> transfer, new capture valid next cycle, counter1 restarts at 1.
REQ-033 EVENT_MASK=0x1, all events high 10 cycles -> only counter0=10; CLEAR with snapshot -> captured 10, next capture 0.
REQ-034 rst asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, all counters 0, DROPPED_COUNT 0.
